mem_access_unit: RTL and testbench

- MEM-stage data-memory bus master; acts as the stall-requesting end of the pipeline-control handshake.
- Takes load/store requests from the EX/MEM register and runs a multi-cycle req/ack transaction on the data bus.
- Holds the pipeline via `mem_stall` while the transaction is in flight.
- Reports alignment, bus and timeout faults to the pipeline controller on `mem_error`, using RISC-V mcause encoding.

---
 rtl/mem_access_unit_if.sv | 29 ++
 rtl/mem_access_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// ============================================================================
// Module      : mem_access_unit_if
// Description : Data-memory bus bundle between the MEM-stage master and memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_unit_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        bus_err;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      input  bus_ack, bus_rdata, bus_err
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      output bus_ack, bus_rdata, bus_err
   );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage load/store bus master with stall request and fault
//               reporting (mcause codes 4..7).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        req_valid,
   input  wire logic        req_we,
   input  wire logic [1:0]  req_size,
   input  wire logic        req_unsigned,
   input  wire logic [31:0] req_addr,
   input  wire logic [31:0] req_wdata,
   input  wire logic        mem_flush,
   output logic             mem_stall,
   output logic             mem_done,
   output logic [31:0]      rdata_out,
   output logic [3:0]       mem_error,
   mem_access_unit_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_cnt_last   = CNT_W'(TIMEOUT - 1);
   localparam logic [3:0]       c_err_none   = 4'd0;
   localparam logic [3:0]       c_err_ld_mis = 4'd4;
   localparam logic [3:0]       c_err_ld_flt = 4'd5;
   localparam logic [3:0]       c_err_st_mis = 4'd6;
   localparam logic [3:0]       c_err_st_flt = 4'd7;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;

   logic             r_bus_req;
   logic             r_bus_we;
   logic [31:0]      r_bus_addr;
   logic [31:0]      r_bus_wdata;
   logic [3:0]       r_bus_wstrb;
   logic [1:0]       r_size;
   logic             r_unsigned;
   logic [1:0]       r_addr_lo;
   logic [31:0]      r_rdata;
   logic [3:0]       r_error;

   logic             w_accept;
   logic             w_misaligned;
   logic             w_timeout;
   logic             w_stall;
   logic             w_done;
   logic [31:0]      w_st_data;
   logic [3:0]       w_st_strb;
   logic [7:0]       w_ld_byte;
   logic [15:0]      w_ld_half;
   logic [31:0]      w_ld_data;

   assign w_accept     = req_valid && !mem_flush;
   assign w_misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                         (req_size[1] && (req_addr[1:0] != 2'b00));
   assign w_timeout    = (r_cnt == c_cnt_last);

   // Store lane replication and byte strobes
   always_comb begin
      w_st_data = req_wdata;
      w_st_strb = 4'b1111;
      case (req_size)
         2'b00: begin
            w_st_data = {4{req_wdata[7:0]}};
            w_st_strb = 4'b0001 << req_addr[1:0];
         end
         2'b01: begin
            w_st_data = {2{req_wdata[15:0]}};
            w_st_strb = 4'b0011 << req_addr[1:0];
         end
         default: begin
            w_st_data = req_wdata;
            w_st_strb = 4'b1111;
         end
      endcase
      if (!req_we) begin
         w_st_strb = 4'b0000;
      end
   end

   // Load lane selection and sign/zero extension
   always_comb begin
      w_ld_byte = 8'h00;
      w_ld_half = r_addr_lo[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
      w_ld_data = bus.bus_rdata;
      case (r_addr_lo)
         2'd0:    w_ld_byte = bus.bus_rdata[7:0];
         2'd1:    w_ld_byte = bus.bus_rdata[15:8];
         2'd2:    w_ld_byte = bus.bus_rdata[23:16];
         default: w_ld_byte = bus.bus_rdata[31:24];
      endcase
      case (r_size)
         2'b00:   w_ld_data = r_unsigned ? {24'h000000, w_ld_byte}
                                         : {{24{w_ld_byte[7]}}, w_ld_byte};
         2'b01:   w_ld_data = r_unsigned ? {16'h0000, w_ld_half}
                                         : {{16{w_ld_half[15]}}, w_ld_half};
         default: w_ld_data = bus.bus_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_misaligned) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_stall     = 1'b1;
                  w_state_nxt = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            w_stall = 1'b1;
            if (bus.bus_ack || w_timeout) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            // req_valid is deliberately ignored so the retiring instruction is not re-issued
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= 32'h0;
         r_bus_wdata <= 32'h0;
         r_bus_wstrb <= 4'b0000;
         r_size      <= 2'b00;
         r_unsigned  <= 1'b0;
         r_addr_lo   <= 2'b00;
         r_rdata     <= 32'h0;
         r_error     <= c_err_none;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (w_accept) begin
                  if (w_misaligned) begin
                     r_error <= req_we ? c_err_st_mis : c_err_ld_mis;
                  end else begin
                     r_bus_req   <= 1'b1;
                     r_bus_we    <= req_we;
                     r_bus_addr  <= {req_addr[31:2], 2'b00};
                     r_bus_wdata <= w_st_data;
                     r_bus_wstrb <= w_st_strb;
                     r_size      <= req_size;
                     r_unsigned  <= req_unsigned;
                     r_addr_lo   <= req_addr[1:0];
                  end
               end
            end
            S_BUSY: begin
               if (bus.bus_ack) begin
                  r_bus_req <= 1'b0;
                  r_cnt     <= '0;
                  r_rdata   <= r_bus_we ? 32'h0 : w_ld_data;
                  if (bus.bus_err) begin
                     r_error <= r_bus_we ? c_err_st_flt : c_err_ld_flt;
                  end else begin
                     r_error <= c_err_none;
                  end
               end else if (w_timeout) begin
                  r_bus_req <= 1'b0;
                  r_cnt     <= '0;
                  r_error   <= r_bus_we ? c_err_st_flt : c_err_ld_flt;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_rdata <= 32'h0;
               r_error <= c_err_none;
            end
            default: begin
               r_bus_req <= 1'b0;
            end
         endcase
      end
   end

   // Reset forces the combinational handshake outputs low as well
   assign mem_stall     = w_stall && !rst;
   assign mem_done      = w_done && !rst;
   assign rdata_out     = r_rdata;
   assign mem_error     = r_error;
   assign bus.bus_req   = r_bus_req;
   assign bus.bus_we    = r_bus_we;
   assign bus.bus_addr  = r_bus_addr;
   assign bus.bus_wdata = r_bus_wdata;
   assign bus.bus_wstrb = r_bus_wstrb;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard bench for mem_access_unit (TIMEOUT = 8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

   typedef struct {
      logic [31:0] rdata;
      logic [3:0]  err;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        mem_flush;
   logic        mem_stall;
   logic        mem_done;
   logic [31:0] rdata_out;
   logic [3:0]  mem_error;

   int   n_checks;
   int   n_fail;
   exp_t sb_q[$];

   mem_access_unit_if bus_if ();

   mem_access_unit #(
      .TIMEOUT (8),
      .CNT_W   (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .mem_flush    (mem_flush),
      .mem_stall    (mem_stall),
      .mem_done     (mem_done),
      .rdata_out    (rdata_out),
      .mem_error    (mem_error),
      .bus          (bus_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Completion monitor: every mem_done pulse must match the oldest expectation
   always @(negedge clk) begin
      if (mem_done === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_rdata", rdata_out, e.rdata);
            check("sb_error", {28'h0, mem_error}, {28'h0, e.err});
         end
      end
   end

   // Drives one request; returns at the negedge of the DONE cycle with req_valid
   // still asserted so the DONE cycle's disregard of req_valid is exercised.
   task automatic run_access(
      input string       tag,
      input logic        we,
      input logic [1:0]  size,
      input logic        uns,
      input logic [31:0] addr,
      input logic [31:0] wdata,
      input int          ack_at,
      input logic        err,
      input logic [31:0] rd,
      input logic [31:0] exp_wdata,
      input logic [3:0]  exp_wstrb,
      input logic [31:0] exp_rdata,
      input logic [3:0]  exp_err,
      input int          exp_busy
   );
      exp_t e;
      int   busy;
      bit   done;
      @(negedge clk);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      e.rdata      = exp_rdata;
      e.err        = exp_err;
      sb_q.push_back(e);
      #1;
      check({tag, "_stall_accept"}, {31'h0, mem_stall}, (exp_busy != 0) ? 32'd1 : 32'd0);
      check({tag, "_idle_rdata"}, rdata_out, 32'h0);
      busy = 0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         bus_if.bus_ack   = 1'b0;
         bus_if.bus_err   = 1'b0;
         bus_if.bus_rdata = 32'h0;
         if (mem_done === 1'b1) begin
            done = 1'b1;
            check({tag, "_done_stall"}, {31'h0, mem_stall}, 32'd0);
            check({tag, "_done_req"}, {31'h0, bus_if.bus_req}, 32'd0);
         end else begin
            busy++;
            check({tag, "_busy_req"}, {31'h0, bus_if.bus_req}, 32'd1);
            check({tag, "_busy_stall"}, {31'h0, mem_stall}, 32'd1);
            check({tag, "_busy_addr"}, bus_if.bus_addr, {addr[31:2], 2'b00});
            check({tag, "_busy_we"}, {31'h0, bus_if.bus_we}, {31'h0, we});
            check({tag, "_busy_wstrb"}, {28'h0, bus_if.bus_wstrb}, {28'h0, exp_wstrb});
            if (we) begin
               check({tag, "_busy_wdata"}, bus_if.bus_wdata, exp_wdata);
            end
            if (busy == ack_at) begin
               bus_if.bus_ack   = 1'b1;
               bus_if.bus_err   = err;
               bus_if.bus_rdata = rd;
            end
         end
      end
      if (!done) begin
         check({tag, "_done_timeout"}, 32'd0, 32'd1);
      end
      check({tag, "_busy_cycles"}, busy, exp_busy);
   endtask

   task automatic idle_check(input string tag);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check({tag, "_idle_done"}, {31'h0, mem_done}, 32'd0);
      check({tag, "_idle_rdata"}, rdata_out, 32'h0);
      check({tag, "_idle_err"}, {28'h0, mem_error}, 32'd0);
      check({tag, "_idle_req"}, {31'h0, bus_if.bus_req}, 32'd0);
   endtask

   initial begin
      n_checks         = 0;
      n_fail           = 0;
      rst              = 1'b1;
      req_valid        = 1'b0;
      req_we           = 1'b0;
      req_size         = 2'b10;
      req_unsigned     = 1'b0;
      req_addr         = 32'h0;
      req_wdata        = 32'h0;
      mem_flush        = 1'b0;
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_err   = 1'b0;
      bus_if.bus_rdata = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_stall", {31'h0, mem_stall}, 32'd0);
      check("rst_done", {31'h0, mem_done}, 32'd0);
      check("rst_req", {31'h0, bus_if.bus_req}, 32'd0);
      check("rst_rdata", rdata_out, 32'h0);
      check("rst_err", {28'h0, mem_error}, 32'd0);
      check("rst_wstrb", {28'h0, bus_if.bus_wstrb}, 32'd0);
      rst = 1'b0;

      run_access("lw",     1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 2, 1'b0, 32'hDEAD_BEEF,
                 32'h0, 4'b0000, 32'hDEAD_BEEF, 4'd0, 2);
      // Back-to-back: next request issued in the IDLE cycle right after DONE
      run_access("sb",     1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_00A5, 3, 1'b0, 32'h0,
                 32'hA5A5_A5A5, 4'b1000, 32'h0, 4'd0, 3);
      run_access("lh",     1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 1, 1'b0, 32'h8001_0000,
                 32'h0, 4'b0000, 32'hFFFF_8001, 4'd0, 1);
      run_access("lhu",    1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 1, 1'b0, 32'h8001_0000,
                 32'h0, 4'b0000, 32'h0000_8001, 4'd0, 1);
      run_access("lb",     1'b0, 2'b00, 1'b0, 32'h0000_0201, 32'h0, 1, 1'b0, 32'h1234_8056,
                 32'h0, 4'b0000, 32'hFFFF_FF80, 4'd0, 1);
      run_access("lbu",    1'b0, 2'b00, 1'b1, 32'h0000_0201, 32'h0, 2, 1'b0, 32'h1234_8056,
                 32'h0, 4'b0000, 32'h0000_0080, 4'd0, 2);
      idle_check("post_lbu");
      run_access("lw_mis", 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 1, 1'b0, 32'h0,
                 32'h0, 4'b0000, 32'h0, 4'd4, 0);
      run_access("sh_mis", 1'b1, 2'b01, 1'b0, 32'h0000_0101, 32'h1234_ABCD, 1, 1'b0, 32'h0,
                 32'h0, 4'b0000, 32'h0, 4'd6, 0);
      run_access("sh",     1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h1234_ABCD, 1, 1'b0, 32'h0,
                 32'hABCD_ABCD, 4'b1100, 32'h0, 4'd0, 1);
      run_access("sw_err", 1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 2, 1'b1, 32'h0,
                 32'hCAFE_F00D, 4'b1111, 32'h0, 4'd7, 2);
      idle_check("post_sw_err");
      run_access("lw_to",  1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 0, 1'b0, 32'h0,
                 32'h0, 4'b0000, 32'h0, 4'd5, 8);
      run_access("lw_sz3", 1'b0, 2'b11, 1'b1, 32'h0000_0204, 32'h0, 1, 1'b0, 32'h8765_4321,
                 32'h0, 4'b0000, 32'h8765_4321, 4'd0, 1);
      idle_check("post_sz3");

      // Flushed request is dropped in IDLE
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_size  = 2'b10;
      req_addr  = 32'h0000_0100;
      mem_flush = 1'b1;
      #1;
      check("flush_stall", {31'h0, mem_stall}, 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      mem_flush = 1'b0;
      #1;
      check("flush_req", {31'h0, bus_if.bus_req}, 32'd0);
      check("flush_done", {31'h0, mem_done}, 32'd0);

      // Reset on the second BUSY cycle aborts the access; a late ack is ignored
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = 32'h0000_0100;
      @(negedge clk);
      check("rstbusy_req1", {31'h0, bus_if.bus_req}, 32'd1);
      @(negedge clk);
      check("rstbusy_req2", {31'h0, bus_if.bus_req}, 32'd1);
      rst       = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      check("rstbusy_req_after", {31'h0, bus_if.bus_req}, 32'd0);
      check("rstbusy_stall_after", {31'h0, mem_stall}, 32'd0);
      rst              = 1'b0;
      bus_if.bus_ack   = 1'b1;
      bus_if.bus_rdata = 32'h1111_1111;
      @(negedge clk);
      bus_if.bus_ack = 1'b0;
      check("late_ack_done", {31'h0, mem_done}, 32'd0);
      @(negedge clk);
      check("late_ack_done2", {31'h0, mem_done}, 32'd0);
      check("late_ack_stall", {31'h0, mem_stall}, 32'd0);

      run_access("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 1, 1'b0, 32'h0BAD_F00D,
                 32'h0, 4'b0000, 32'h0BAD_F00D, 4'd0, 1);
      idle_check("final");
      repeat (2) @(negedge clk);
      check("sb_drained", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule

`default_nettype wire
